mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one 8x8 unsigned multiplier between NUM_REQ requesters.
- Accepts one operand pair at a time via valid/ready, drives the multiplier, and returns the 16-bit product tagged with the requester index on a single valid/ready result port.
- Sits between the requester blocks and the shared multiply resource.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- PIPE_STAGES, 1, multiplier latency in cycles from operand register to product register, 1..4.
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ), min 1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  8*NUM_REQ  operand A, requester i at bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, same packing as req_a.
- res_valid  out  1  product valid.
- res_ready  in  1  consumer accepts product.
- res_id  out  ID_W  index of the requester that owns res_data.
- res_data  out  16  unsigned product a*b.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  completed-operation counter, saturating at 16'hFFFF.

Behaviour:
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: req_ready=0, res_valid=0, res_id=0, res_data=0, busy=0, op_count=0, ptr=0, latency counter=0.
- IDLE:
  - Grant is combinational: scan req_valid starting at index ptr, ascending, wrapping at NUM_REQ-1 to 0. The first set bit g gets req_ready[g]=1; all other req_ready bits are 0.
  - On handshake (req_valid[g] & req_ready[g]) at cycle T: latch req_a[g], req_b[g] and g into the operand registers. Set ptr <= (g+1) mod NUM_REQ. Go to BUSY.
  - With no req_valid set, stay in IDLE with ptr unchanged.
- BUSY:
  - req_ready is all zero.
  - Latency counter loads PIPE_STAGES-1 on entry and decrements each cycle.
  - When the counter reaches 0, the product register captures the result. Go to DONE.
- DONE:
  - res_valid=1. res_id and res_data are stable until the handshake.
  - On res_valid & res_ready: op_count increments (unless saturated) and the state returns to IDLE.
  - No new request is accepted in the DONE cycle.
- Latency: request accepted at T gives res_valid first high at T+PIPE_STAGES+1.
- Minimum spacing between consecutive accepts is PIPE_STAGES+2 cycles when res_ready is held high.
- Arithmetic: 8x8 unsigned multiply, full 16-bit result, no truncation. 255*255 = 16'hFE01.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Requester protocol: a requester must hold req_valid and its operands stable until req_ready. A requester dropping req_valid before grant is simply skipped.
- res_ready low in DONE: hold indefinitely with outputs unchanged. New req_valid inputs are ignored and req_ready stays 0.
- Reset mid-operation: the in-flight operation is discarded, all outputs return to reset values immediately, and ptr returns to 0.
- busy = (state != IDLE).

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - constants OPW=8 and PRODW=16;
  - a clog2-style function for ID_W checking.
- Sub-module mult_8x8_pipe (clk, rst_n, a, b, p) with PIPE_STAGES register stages.
  - The arbiter instantiates it.
  - The arbiter FSM counts latency rather than using a valid chain.

Test Plan:
- Single request: req_valid=4'b0100, a=8'd12, b=8'd13, res_ready=1. Required: req_ready=4'b0100 at T; res_valid at T+2 with res_id=2, res_data=16'd156; op_count=1.
- All four requesters valid continuously with distinct operands. Required: grant order 0,1,2,3,0; each res_id matches the grant; accepts spaced exactly 3 cycles apart with PIPE_STAGES=1.
- Backpressure: res_ready=0 for 10 cycles after res_valid. Required: res_data and res_id stable, req_ready=0 throughout; completion occurs on the cycle res_ready goes high; IDLE on the next cycle.
- Boundaries: a=b=255 gives 16'hFE01; a=0, b=200 gives 0. Wrap case: ptr=3 with only req 0 valid grants req 0 and sets ptr to 1.
- Reset: rst_n low during BUSY for 1 cycle. Required: outputs return to reset values asynchronously, with no res_valid for the aborted op. The next request completes normally with op_count=1 counted from the post-reset state.
- PIPE_STAGES=3 build: accept at T gives res_valid at T+4 with the correct product. op_count saturates at 16'hFFFF after forced preload.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the round-robin multiplier
//                arbiter. Provides the sequencer state encoding, operand and
//                product widths, and a clog2-style helper that is used to
//                check the requester-index width.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int OPW   = 8;
    localparam int PRODW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_8x8_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_8x8_pipe
//  Description : Unsigned 8x8 multiplier with PIPE_STAGES register stages.
//                The first stage registers the product of the inputs; any
//                further stages delay it. Output p is the last stage.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                a, b   - operands
//                p      - full 16-bit product, PIPE_STAGES cycles after a/b
//  Revision    : 1.0  initial release
// ============================================================================
module mult_8x8_pipe
    import mult_pkg::*;
#(
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] p
);

    logic [PRODW-1:0] r_stage [PIPE_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= PRODW'(a) * PRODW'(b);
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign p = r_stage[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_rr_arbiter
//  Description : Round-robin sequencer sharing one 8x8 unsigned multiplier
//                among NUM_REQ requesters. One operand pair is accepted at a
//                time, multiplied, and the product is returned tagged with
//                the owning requester index.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                req_valid  - per-requester operand valid
//                req_ready  - per-requester accept (one-hot or zero)
//                req_a/b    - packed operands, requester i at [8i+7:8i]
//                res_valid  - product valid
//                res_ready  - consumer accepts product
//                res_id     - requester owning res_data
//                res_data   - 16-bit product
//                busy       - sequencer not idle
//                op_count   - completed operations, saturating
//  Revision    : 1.0  initial release
// ============================================================================
module mult_rr_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 1,
    parameter int ID_W        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [OPW*NUM_REQ-1:0] req_a,
    input  logic [OPW*NUM_REQ-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [PRODW-1:0]       res_data,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam int c_LAT_W = 3;

    generate
        if (ID_W != clog2_min1(NUM_REQ)) begin : g_bad_id_w
            $error("ID_W must equal clog2(NUM_REQ)");
        end
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
            $error("PIPE_STAGES must be 1..4");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_op_id;
    logic [OPW-1:0]       r_op_a;
    logic [OPW-1:0]       r_op_b;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic [15:0]          r_op_count;

    logic                 w_grant_found;
    logic [ID_W-1:0]      w_grant_idx;
    logic [ID_W:0]        w_scan_sum;
    logic [NUM_REQ-1:0]   w_grant_onehot;
    logic [OPW-1:0]       w_sel_a;
    logic [OPW-1:0]       w_sel_b;
    logic [ID_W-1:0]      w_ptr_next;
    logic                 w_accept;
    logic                 w_complete;
    logic [PRODW-1:0]     w_product;

    // ------------------------------------------------------------------
    // Round-robin scan starting at r_ptr. Walking the offsets from high
    // to low lets the smallest offset with a valid request win.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_scan_sum = w_scan_sum - (ID_W+1)'(NUM_REQ);
            end
            if (req_valid[w_scan_sum[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_sum[ID_W-1:0];
            end
        end
    end

    assign w_grant_onehot = w_grant_found ? (NUM_REQ'(1) << w_grant_idx) : '0;

    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                            : w_grant_idx + ID_W'(1);

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_a = req_a[i*OPW +: OPW];
                w_sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. req_ready is combinational from
    // req_valid, so it is also qualified by rst_n to read zero while
    // reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && w_grant_found) begin
                    req_ready    = w_grant_onehot;
                    w_accept     = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (r_lat_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture, pointer, latency counter and completion counter.
    // Operands only change on accept, so the multiplier output settles on
    // the new product and stays there through DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_op_id    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_lat_cnt  <= '0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_op_a    <= w_sel_a;
                r_op_b    <= w_sel_b;
                r_op_id   <= w_grant_idx;
                r_ptr     <= w_ptr_next;
                r_lat_cnt <= c_LAT_W'(PIPE_STAGES - 1);
            end else if (r_state == BUSY && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end

            if (w_complete && r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    // The last pipe stage acts as the product register: with BUSY lasting
    // PIPE_STAGES cycles, it holds the new product on DONE entry.
    mult_8x8_pipe #(
        .PIPE_STAGES (PIPE_STAGES)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (r_op_a),
        .b     (r_op_b),
        .p     (w_product)
    );

    assign res_valid = (r_state == DONE);
    assign res_id    = r_op_id;
    assign res_data  = w_product;
    assign busy      = (r_state != IDLE);
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_rr_arbiter
//  Description : Directed self-checking bench for mult_rr_arbiter. One
//                instance uses PIPE_STAGES=1, a second uses PIPE_STAGES=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_rr_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic        busy;
    logic [15:0] op_count;

    logic [3:0]  req_valid3 = '0;
    logic [3:0]  req_ready3;
    logic [31:0] req_a3 = '0;
    logic [31:0] req_b3 = '0;
    logic        res_valid3;
    logic        res_ready3 = 1'b1;
    logic [1:0]  res_id3;
    logic [15:0] res_data3;
    logic        busy3;
    logic [15:0] op_count3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_rr_arbiter #(.NUM_REQ(4), .PIPE_STAGES(1), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data),
        .busy(busy), .op_count(op_count)
    );

    mult_rr_arbiter #(.NUM_REQ(4), .PIPE_STAGES(3), .ID_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_id(res_id3), .res_data(res_data3),
        .busy(busy3), .op_count(op_count3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, record req_ready, wait (bounded) for the result
    // and let it complete with res_ready high. lat counts cycles from the
    // accept edge to the first res_valid.
    task automatic run_op(input logic [3:0] vmask, input int idx,
                          input logic [7:0] a, input logic [7:0] b,
                          output logic [3:0] rdy, output int lat,
                          output logic [1:0] id, output logic [15:0] data);
        req_valid = vmask;
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
        res_ready = 1'b1;
        #1;
        rdy = req_ready;
        step();
        req_valid = '0;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        id   = res_id;
        data = res_data;
        step();
    endtask

    task automatic run_op3(input logic [3:0] vmask, input int idx,
                           input logic [7:0] a, input logic [7:0] b,
                           output logic [3:0] rdy, output int lat,
                           output logic [1:0] id, output logic [15:0] data);
        req_valid3 = vmask;
        req_a3[8*idx +: 8] = a;
        req_b3[8*idx +: 8] = b;
        res_ready3 = 1'b1;
        #1;
        rdy = req_ready3;
        step();
        req_valid3 = '0;
        lat = 1;
        while (res_valid3 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        id   = res_id3;
        data = res_data3;
        step();
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #2;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        total++; if (res_id !== 2'd0 || res_data !== 16'd0) begin bad++; $display("FAIL reset_res: got id=%0d data=%0h expected 0/0", res_id, res_data); end
        total++; if (busy !== 1'b0 || op_count !== 16'd0) begin bad++; $display("FAIL reset_busy_count: got busy=%b count=%0d expected 0/0", busy, op_count); end
        total++; if (busy3 !== 1'b0 || op_count3 !== 16'd0 || res_valid3 !== 1'b0) begin bad++; $display("FAIL reset_dut3: got busy=%b count=%0d valid=%b expected 0", busy3, op_count3, res_valid3); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [3:0]  rdy;
        int          lat;
        logic [1:0]  id;
        logic [15:0] data;
        run_op(4'b0100, 2, 8'd12, 8'd13, rdy, lat, id, data);
        total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b expected 0100", rdy); end
        total++; if (lat != 2) begin bad++; $display("FAIL single_latency: got %0d expected 2", lat); end
        total++; if (id !== 2'd2 || data !== 16'd156) begin bad++; $display("FAIL single_result: got id=%0d data=%0d expected 2/156", id, data); end
        total++; if (op_count !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL single_count: got count=%0d busy=%b expected 1/0", op_count, busy); end
    endtask

    // ptr is 3 here; only requester 0 valid must still be granted.
    task automatic test_wrap();
        logic [3:0]  rdy;
        int          lat;
        logic [1:0]  id;
        logic [15:0] data;
        run_op(4'b0001, 0, 8'd0, 8'd200, rdy, lat, id, data);
        total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL wrap_ready: got %b expected 0001", rdy); end
        total++; if (id !== 2'd0 || data !== 16'd0) begin bad++; $display("FAIL zero_operand: got id=%0d data=%0d expected 0/0", id, data); end
        // ptr must now be 1: with 0 and 3 valid, 3 comes first.
        run_op(4'b1001, 3, 8'd7, 8'd9, rdy, lat, id, data);
        total++; if (rdy !== 4'b1000) begin bad++; $display("FAIL wrap_ptr_next: got %b expected 1000", rdy); end
        total++; if (id !== 2'd3 || data !== 16'd63) begin bad++; $display("FAIL wrap_result: got id=%0d data=%0d expected 3/63", id, data); end
        total++; if (op_count !== 16'd3) begin bad++; $display("FAIL wrap_count: got %0d expected 3", op_count); end
    endtask

    task automatic test_round_robin();
        int          exp_g [5];
        logic [15:0] prod  [4];
        int ng, nres, cyc, last;
        exp_g = '{0, 1, 2, 3, 0};
        prod  = '{16'd200, 16'd231, 16'd264, 16'd299};
        ng = 0; nres = 0; cyc = 0; last = 0;
        req_a = {8'd13, 8'd12, 8'd11, 8'd10};
        req_b = {8'd23, 8'd22, 8'd21, 8'd20};
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        while ((ng < 5 || nres < 5) && cyc < 60) begin
            if (req_ready !== 4'b0000 && ng < 5) begin
                total++;
                if (req_ready !== (4'b0001 << exp_g[ng])) begin
                    bad++; $display("FAIL rr_grant%0d: got %b expected index %0d", ng, req_ready, exp_g[ng]);
                end
                if (ng > 0) begin
                    total++;
                    if (cyc - last != 3) begin bad++; $display("FAIL rr_spacing%0d: got %0d expected 3", ng, cyc - last); end
                end
                last = cyc;
                ng++;
            end
            if (res_valid === 1'b1 && nres < 5) begin
                total++;
                if (res_id !== 2'(exp_g[nres]) || res_data !== prod[exp_g[nres]]) begin
                    bad++; $display("FAIL rr_result%0d: got id=%0d data=%0d expected %0d/%0d", nres, res_id, res_data, exp_g[nres], prod[exp_g[nres]]);
                end
                nres++;
            end
            @(posedge clk);
            #2;
            cyc++;
            if (ng == 5) req_valid = 4'b0000;
        end
        req_valid = 4'b0000;
        total++; if (ng != 5 || nres != 5) begin bad++; $display("FAIL rr_timeout: got grants=%0d results=%0d expected 5/5", ng, nres); end
        total++; if (op_count !== 16'd8) begin bad++; $display("FAIL rr_count: got %0d expected 8", op_count); end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        req_a[15:8] = 8'd200;
        req_b[15:8] = 8'd3;
        res_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_ready: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'd600) begin bad++; $display("FAIL bp_first: got v=%b id=%0d data=%0d expected 1/1/600", res_valid, res_id, res_data); end
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'd600 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d data=%0d rdy=%b expected 1/1/600/0000", i, res_valid, res_id, res_data, req_ready);
            end
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        total++; if (res_valid !== 1'b1 || req_ready !== 4'b0000 || op_count !== 16'd8) begin bad++; $display("FAIL bp_release: got v=%b rdy=%b count=%0d expected 1/0000/8", res_valid, req_ready, op_count); end
        step();
        total++; if (res_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd9) begin bad++; $display("FAIL bp_done: got v=%b busy=%b count=%0d expected 0/0/9", res_valid, busy, op_count); end
    endtask

    task automatic test_boundaries();
        logic [3:0]  rdy;
        int          lat;
        logic [1:0]  id;
        logic [15:0] data;
        run_op(4'b0100, 2, 8'd255, 8'd255, rdy, lat, id, data);
        total++; if (rdy !== 4'b0100 || id !== 2'd2 || data !== 16'hFE01) begin bad++; $display("FAIL max_operands: got rdy=%b id=%0d data=%0h expected 0100/2/fe01", rdy, id, data); end
        run_op(4'b1000, 3, 8'd255, 8'd1, rdy, lat, id, data);
        total++; if (id !== 2'd3 || data !== 16'd255) begin bad++; $display("FAIL one_operand: got id=%0d data=%0d expected 3/255", id, data); end
        total++; if (op_count !== 16'd11) begin bad++; $display("FAIL bound_count: got %0d expected 11", op_count); end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  rdy;
        int          lat;
        logic [1:0]  id;
        logic [15:0] data;
        int          seen;
        // ptr is 0 here; request 2 so res_id would be non-zero if kept.
        req_valid = 4'b0100;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd5;
        res_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_reset_ctrl: got busy=%b v=%b rdy=%b expected 0/0/0000", busy, res_valid, req_ready); end
        total++; if (res_id !== 2'd0 || res_data !== 16'd0 || op_count !== 16'd0) begin bad++; $display("FAIL mid_reset_data: got id=%0d data=%0d count=%0d expected 0/0/0", res_id, res_data, op_count); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        step();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid === 1'b1) seen++;
            step();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_aborted_result: got %0d valid cycles expected 0", seen); end
        run_op(4'b1111, 0, 8'd9, 8'd9, rdy, lat, id, data);
        total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset: got %b expected 0001", rdy); end
        total++; if (id !== 2'd0 || data !== 16'd81 || op_count !== 16'd1) begin bad++; $display("FAIL mid_after: got id=%0d data=%0d count=%0d expected 0/81/1", id, data, op_count); end
    endtask

    task automatic test_pipe3();
        logic [3:0]  rdy;
        int          lat;
        logic [1:0]  id;
        logic [15:0] data;
        run_op3(4'b0001, 0, 8'd100, 8'd100, rdy, lat, id, data);
        total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL p3_ready: got %b expected 0001", rdy); end
        total++; if (lat != 4) begin bad++; $display("FAIL p3_latency: got %0d expected 4", lat); end
        total++; if (id !== 2'd0 || data !== 16'd10000 || op_count3 !== 16'd1) begin bad++; $display("FAIL p3_result: got id=%0d data=%0d count=%0d expected 0/10000/1", id, data, op_count3); end
        force dut3.r_op_count = 16'hFFFE;
        #1;
        release dut3.r_op_count;
        #1;
        total++; if (op_count3 !== 16'hFFFE) begin bad++; $display("FAIL p3_preload: got %0h expected fffe", op_count3); end
        run_op3(4'b0010, 1, 8'd255, 8'd255, rdy, lat, id, data);
        total++; if (lat != 4 || id !== 2'd1 || data !== 16'hFE01) begin bad++; $display("FAIL p3_max: got lat=%0d id=%0d data=%0h expected 4/1/fe01", lat, id, data); end
        total++; if (op_count3 !== 16'hFFFF) begin bad++; $display("FAIL p3_count_top: got %0h expected ffff", op_count3); end
        run_op3(4'b0100, 2, 8'd2, 8'd3, rdy, lat, id, data);
        total++; if (id !== 2'd2 || data !== 16'd6) begin bad++; $display("FAIL p3_small: got id=%0d data=%0d expected 2/6", id, data); end
        total++; if (op_count3 !== 16'hFFFF) begin bad++; $display("FAIL p3_saturate: got %0h expected ffff", op_count3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
        test_pipe3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
